// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator for the HDMI/DVI output path.
//   It keeps an internal pixel/line counter pair (h_cnt, v_cnt). From that pair it
//   derives registered coordinates, the data enable, polarity-configurable h/v sync
//   and frame/line markers. It also produces a look-ahead pixel request so that
//   pattern or framebuffer pipelines of any depth line up with DE.
//   All outputs are registered. Outputs in cycle t+1 describe the counters at cycle t.
//
// Ports
//   pixclk      in   pixel clock, the only clock
//   reset       in   synchronous, active-high reset
//   enable      in   1: raster advances, 0: raster frozen
//   x, y        out  position described by the current output cycle (CW bits)
//   de          out  data enable (x < H_ACTIVE && y < V_ACTIVE)
//   hsync       out  horizontal sync, active level set by H_POL
//   vsync       out  vertical sync, active level set by V_POL
//   pix_req     out  request for the pixel shown LOOKAHEAD cycles later
//   sof         out  one-cycle pulse at x=0, y=0
//   eol         out  one-cycle pulse at x=H_ACTIVE-1 on active lines
//   frame_count out  frames started, 16 bits, wraps
//
// Configuration macro
//   VTG_FRAME_COUNT_EN  When defined, this adds the frame_count port and its counter.
//                       When undefined, the port and the counter are absent.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int H_POL     = 1,
  parameter int V_POL     = 1,
  parameter int LOOKAHEAD = 1,
  parameter int CW        = 12
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          pix_req,
  output logic          sof,
  output logic          eol
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EOL   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0]   LA_W    = (CW+1)'(LOOKAHEAD);
  localparam logic [CW:0]   HTOT_W  = (CW+1)'(H_TOTAL);
  localparam logic          HS_ON   = (H_POL != 0);
  localparam logic          VS_ON   = (V_POL != 0);

  // Elaboration-time parameter checks
  if (LOOKAHEAD < 0 || LOOKAHEAD > H_TOTAL - H_ACTIVE - 1) begin : g_bad_lookahead
    $error("video_timing_gen: LOOKAHEAD must be in 0..H_TOTAL-H_ACTIVE-1");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("video_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sizes
    $error("video_timing_gen: active and sync sizes must be non-zero");
  end

  function automatic logic active_at(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  function automatic logic sync_at(input logic [CW-1:0] pos, input logic [CW-1:0] beg,
                                   input logic [CW-1:0] fin, input logic on_lvl);
    return ((pos >= beg) && (pos < fin)) ? on_lvl : ~on_lvl;
  endfunction

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic          pr_q, pr_d, sof_q, sof_d, eol_q, eol_d;
  logic [CW:0]   h_sum;
  logic [CW-1:0] h_ahead, v_ahead;

  // Stage 0: raster counters and the position LOOKAHEAD pixels ahead
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (enable) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
      end else begin
        h_cnt_d = h_cnt_q + ONE;
      end
    end
  end

  // LOOKAHEAD < H_TOTAL, so at most one line wrap and one subtraction are needed.
  always_comb begin
    h_sum   = {1'b0, h_cnt_q} + LA_W;
    h_ahead = h_sum[CW-1:0];
    v_ahead = v_cnt_q;
    if (h_sum >= HTOT_W) begin
      h_ahead = CW'(h_sum - HTOT_W);
      v_ahead = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
    end
  end

  // Stage 1: registered outputs. While frozen, the pulses and enables drop and the
  // coordinates and syncs keep their last values.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = 1'b0;
    pr_d  = 1'b0;
    sof_d = 1'b0;
    eol_d = 1'b0;
    if (enable) begin
      x_d   = h_cnt_q;
      y_d   = v_cnt_q;
      hs_d  = sync_at(h_cnt_q, HS_BEG, HS_END, HS_ON);
      vs_d  = sync_at(v_cnt_q, VS_BEG, VS_END, VS_ON);
      de_d  = active_at(h_cnt_q, v_cnt_q);
      pr_d  = active_at(h_ahead, v_ahead);
      sof_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      eol_d = (h_cnt_q == H_EOL) && (v_cnt_q < V_ACT);
    end
  end

  // Reset starts at the top of the vertical front porch. This lets the look-ahead
  // pipeline fill before the first active pixel.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= V_ACT;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      pr_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      pr_q    <= pr_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] fc_q;

  // The count steps on the same edge that raises sof, so it reads 1 during the first sof.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      fc_q <= '0;
    end else if (sof_d) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_count = fc_q;
`endif

  assign x       = x_q;
  assign y       = y_q;
  assign de      = de_q;
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign pix_req = pr_q;
  assign sof     = sof_q;
  assign eol     = eol_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen.
// DUT A: H 8/2/2/2 (total 14), V 4/1/1/2 (total 8), LOOKAHEAD=3, active-high syncs.
// DUT B: H 4/1/1/1 (total 7), V 2/1/1/1 (total 5), H_POL=0, LOOKAHEAD=1.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_a, en_a;
  logic [7:0] xa, ya;
  logic       de_a, hs_a, vs_a, pr_a, sof_a, eol_a;
  logic       rst_b, en_b;
  logic [5:0] xb, yb;
  logic       de_b, hs_b, vs_b, pr_b, sof_b, eol_b;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .H_POL(1), .V_POL(1), .LOOKAHEAD(3), .CW(8)
  ) dut_a (
    .pixclk(clk), .reset(rst_a), .enable(en_a),
    .x(xa), .y(ya), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .pix_req(pr_a), .sof(sof_a), .eol(eol_a)
`ifdef VTG_FRAME_COUNT_EN
    , .frame_count(fc_a)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(0), .V_POL(1), .LOOKAHEAD(1), .CW(6)
  ) dut_b (
    .pixclk(clk), .reset(rst_b), .enable(en_b),
    .x(xb), .y(yb), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .pix_req(pr_b), .sof(sof_b), .eol(eol_b)
`ifdef VTG_FRAME_COUNT_EN
    , .frame_count(fc_b)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input int wx, input int wy, input string name);
    int n = 0;
    while (!(int'(xa) == wx && int'(ya) == wy) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: position (%0d,%0d) not reached, at (%0d,%0d)", name, wx, wy, xa, ya);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    repeat (3) tick();
    checks++;
    if ({xa, ya} !== 16'h0000) begin
      errors++; $display("FAIL reset_xy: got x=%0d y=%0d want 0,0", xa, ya);
    end
    checks++;
    if ({de_a, hs_a, vs_a, pr_a, sof_a, eol_a} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {de_a, hs_a, vs_a, pr_a, sof_a, eol_a});
    end
`ifdef VTG_FRAME_COUNT_EN
    checks++;
    if (fc_a !== 16'd0) begin
      errors++; $display("FAIL reset_fc: got %0d want 0", fc_a);
    end
`endif
  endtask

  task automatic test_first_sof;
    int n = 0;
    logic [7:0] x1, y1;
    x1 = '1; y1 = '1;
    rst_a = 1'b0;
    do begin
      tick();
      n++;
      if (n == 1) begin x1 = xa; y1 = ya; end
    end while (sof_a !== 1'b1 && n < 200);
    checks++;
    if (x1 !== 8'd0 || y1 !== 8'd4) begin
      errors++; $display("FAIL first_pos: got x=%0d y=%0d want 0,4", x1, y1);
    end
    checks++;
    if (n != 57) begin
      errors++; $display("FAIL first_sof_latency: got %0d want 57", n);
    end
    checks++;
    if (xa !== 8'd0 || ya !== 8'd0 || de_a !== 1'b1) begin
      errors++; $display("FAIL sof_pos: got x=%0d y=%0d de=%0d want 0,0,1", xa, ya, de_a);
    end
  endtask

  // Called on the sof sample; records 115 samples (one frame plus LOOKAHEAD).
  task automatic test_frame;
    logic de_h [115];
    logic pr_h [115];
    logic sof_h[115];
    int c_de = 0, c_hs = 0, c_vs = 0, c_pr = 0, c_eol = 0, c_sof = 0;
    int bad_pos = 0, bad_de = 0, bad_hs = 0, bad_vs = 0, bad_eol = 0, bad_lead = 0;
    for (int i = 0; i < 115; i++) begin
      if (i > 0) tick();
      de_h[i] = de_a; pr_h[i] = pr_a; sof_h[i] = sof_a;
      if (i < 112) begin
        int ex = i % 14;
        int ey = i / 14;
        if (int'(xa) != ex || int'(ya) != ey) bad_pos++;
        if (de_a !== (ex < 8 && ey < 4)) bad_de++;
        if (hs_a !== (ex >= 10 && ex < 12)) bad_hs++;
        if (vs_a !== (ey == 5)) bad_vs++;
        if (eol_a !== (ex == 7 && ey < 4)) bad_eol++;
        c_de += int'(de_a); c_hs += int'(hs_a); c_vs += int'(vs_a);
        c_pr += int'(pr_a); c_eol += int'(eol_a); c_sof += int'(sof_a);
      end
    end
    for (int i = 0; i < 112; i++) if (pr_h[i] !== de_h[i+3]) bad_lead++;
    checks++; if (bad_pos != 0) begin errors++; $display("FAIL frame_xy: bad=%0d want 0", bad_pos); end
    checks++; if (bad_de != 0) begin errors++; $display("FAIL frame_de: bad=%0d want 0", bad_de); end
    checks++; if (bad_hs != 0) begin errors++; $display("FAIL frame_hsync: bad=%0d want 0", bad_hs); end
    checks++; if (bad_vs != 0) begin errors++; $display("FAIL frame_vsync: bad=%0d want 0", bad_vs); end
    checks++; if (bad_eol != 0) begin errors++; $display("FAIL frame_eol: bad=%0d want 0", bad_eol); end
    checks++; if (bad_lead != 0) begin errors++; $display("FAIL pixreq_lead3: bad=%0d want 0", bad_lead); end
    checks++;
    if (c_de != 32 || c_hs != 16 || c_vs != 14 || c_pr != 32 || c_eol != 4 || c_sof != 1) begin
      errors++;
      $display("FAIL frame_counts: de=%0d hs=%0d vs=%0d pr=%0d eol=%0d sof=%0d want 32 16 14 32 4 1",
               c_de, c_hs, c_vs, c_pr, c_eol, c_sof);
    end
    checks++;
    if (sof_h[112] !== 1'b1) begin
      errors++; $display("FAIL frame_period: sof at +112 got %0d want 1", sof_h[112]);
    end
  endtask

  task automatic test_enable;
    int de_cnt = 0, n = 0, bad_freeze = 0, bad_hold = 0;
    wait_a(0, 1, "enable_seek");
    de_cnt += int'(de_a);
    while (xa !== 8'd3 && n < 20) begin tick(); n++; de_cnt += int'(de_a); end
    en_a = 1'b0;
    repeat (10) begin
      tick();
      if (xa !== 8'd3 || ya !== 8'd1 || de_a !== 1'b0 || pr_a !== 1'b0) bad_freeze++;
    end
    checks++;
    if (bad_freeze != 0) begin errors++; $display("FAIL freeze_active: bad=%0d want 0", bad_freeze); end
    en_a = 1'b1;
    tick();
    de_cnt += int'(de_a);
    checks++;
    if (xa !== 8'd4 || ya !== 8'd1 || de_a !== 1'b1) begin
      errors++; $display("FAIL resume_active: got x=%0d y=%0d de=%0d want 4,1,1", xa, ya, de_a);
    end
    n = 0;
    while (xa !== 8'd10 && n < 20) begin tick(); n++; de_cnt += int'(de_a); end
    checks++;
    if (hs_a !== 1'b1) begin errors++; $display("FAIL hsync_at_x10: got %0d want 1", hs_a); end
    en_a = 1'b0;
    repeat (5) begin
      tick();
      if (hs_a !== 1'b1 || xa !== 8'd10 || vs_a !== 1'b0) bad_hold++;
    end
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL freeze_sync_hold: bad=%0d want 0", bad_hold); end
    en_a = 1'b1;
    tick();
    checks++;
    if (xa !== 8'd11) begin errors++; $display("FAIL resume_sync: got x=%0d want 11", xa); end
    n = 0;
    while (xa !== 8'd13 && n < 20) begin tick(); n++; de_cnt += int'(de_a); end
    checks++;
    if (de_cnt != 8) begin errors++; $display("FAIL line_de_total: got %0d want 8", de_cnt); end
  endtask

  task automatic test_reset_mid(input int wx, input int wy, input string name);
    int n = 1;
    wait_a(wx, wy, name);
    rst_a = 1'b1;
    tick();
    checks++;
    if ({de_a, hs_a, vs_a, pr_a, sof_a, eol_a} !== 6'b000000 || xa !== 8'd0 || ya !== 8'd0) begin
      errors++;
      $display("FAIL %s_flags: got flags=%b x=%0d y=%0d want 000000,0,0", name,
               {de_a, hs_a, vs_a, pr_a, sof_a, eol_a}, xa, ya);
    end
    rst_a = 1'b0;
    tick();
    checks++;
    if (xa !== 8'd0 || ya !== 8'd4) begin
      errors++; $display("FAIL %s_restart: got x=%0d y=%0d want 0,4", name, xa, ya);
    end
    while (sof_a !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (n != 57) begin errors++; $display("FAIL %s_sof: got %0d want 57", name, n); end
  endtask

  task automatic test_small_lowpol;
    int n = 0, c_hl = 0, c_de = 0, c_vs = 0, bad_hs = 0;
    checks++;
    if (hs_b !== 1'b1 || vs_b !== 1'b0 || de_b !== 1'b0) begin
      errors++; $display("FAIL b_reset_sync: got hs=%0d vs=%0d de=%0d want 1,0,0", hs_b, vs_b, de_b);
    end
    rst_b = 1'b0;
    do begin tick(); n++; end while (sof_b !== 1'b1 && n < 100);
    checks++;
    if (n != 22) begin errors++; $display("FAIL b_first_sof: got %0d want 22", n); end
`ifdef VTG_FRAME_COUNT_EN
    checks++;
    if (fc_b !== 16'd1) begin errors++; $display("FAIL b_fc1: got %0d want 1", fc_b); end
`endif
    for (int i = 0; i < 35; i++) begin
      if ((hs_b == 1'b0) != (xb == 6'd5)) bad_hs++;
      c_hl += int'(!hs_b); c_de += int'(de_b); c_vs += int'(vs_b);
      tick();
    end
    checks++;
    if (bad_hs != 0 || c_hl != 5) begin
      errors++; $display("FAIL b_hsync_low: bad=%0d lows=%0d want 0,5", bad_hs, c_hl);
    end
    checks++;
    if (c_de != 8 || c_vs != 7) begin
      errors++; $display("FAIL b_counts: de=%0d vs=%0d want 8,7", c_de, c_vs);
    end
    checks++;
    if (sof_b !== 1'b1) begin errors++; $display("FAIL b_frame35: sof got %0d want 1", sof_b); end
`ifdef VTG_FRAME_COUNT_EN
    checks++;
    if (fc_b !== 16'd2) begin errors++; $display("FAIL b_fc2: got %0d want 2", fc_b); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_sof();
    test_frame();
    test_enable();
    test_reset_mid(5, 2, "reset_active");
    test_reset_mid(9, 5, "reset_sync");
    test_small_lowpol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
